// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared 800x600 timing constants, coordinate/RGB widths and helpers
// for video_timing_gen and its axis counters.
package video_timing_pkg;

   // Coordinate and counter width; covers totals up to 2048 per axis
   localparam int unsigned COORD_W = 11;
   localparam int unsigned RGB_W   = 24;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [RGB_W-1:0]   rgb_t;

   localparam rgb_t BLACK = 24'h000000;

   // Sum of the four segments of one axis
   function automatic int unsigned axis_total(input int unsigned sync, input int unsigned back,
                                              input int unsigned disp, input int unsigned front);
      return sync + back + disp + front;
   endfunction

   // 800x600 timing
   localparam int unsigned H_SYNC_800  = 120;
   localparam int unsigned H_BACK_800  = 64;
   localparam int unsigned H_DISP_800  = 800;
   localparam int unsigned H_FRONT_800 = 56;
   localparam int unsigned V_SYNC_800  = 6;
   localparam int unsigned V_BACK_800  = 23;
   localparam int unsigned V_DISP_800  = 600;
   localparam int unsigned V_FRONT_800 = 37;

   localparam int unsigned H_TOTAL_800 =
      axis_total(H_SYNC_800, H_BACK_800, H_DISP_800, H_FRONT_800);
   localparam int unsigned V_TOTAL_800 =
      axis_total(V_SYNC_800, V_BACK_800, V_DISP_800, V_FRONT_800);

endpackage

// File: rtl/vtg_axis_counter.sv
// vtg_axis_counter: wrap counter for one video axis with carry-out and a
// sync / active-window decode. Segment order is sync, back porch, active, front porch.
module vtg_axis_counter
   import video_timing_pkg::*;
#(
   parameter int unsigned Sync  = 4,
   parameter int unsigned Back  = 4,
   parameter int unsigned Disp  = 16,
   parameter int unsigned Front = 4
) (
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   en_i,
   output coord_t cnt_o,
   output logic   wrap_o,
   output logic   sync_o,
   output logic   active_o
);

   localparam int unsigned Total = axis_total(Sync, Back, Disp, Front);
   localparam coord_t Last     = coord_t'(Total - 1);
   localparam coord_t SyncEnd  = coord_t'(Sync);
   localparam coord_t ActStart = coord_t'(Sync + Back);
   localparam coord_t ActEnd   = coord_t'(Sync + Back + Disp);

   if (Total < 2 || Total > (1 << COORD_W)) begin : g_total_check
      $error("vtg_axis_counter: axis total out of range for the coordinate width");
   end

   coord_t cnt_d, cnt_q;

   // Next count: advance when enabled, wrap to 0 after the last position
   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = (cnt_q == Last) ? '0 : cnt_q + coord_t'(1);
      end
   end

   // Count register with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o    = cnt_q;
   assign wrap_o   = en_i && (cnt_q == Last);
   assign sync_o   = cnt_q < SyncEnd;
   assign active_o = (cnt_q >= ActStart) && (cnt_q < ActEnd);

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: sync / data-enable generator with early pixel coordinates for the
// colour stage and a registered RGB888 output aligned to video_de.
// Optional build macro VTG_BLANK_RGB_EN: force video_rgb to black whenever video_de is 0.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int unsigned H_SYNC   = H_SYNC_800,
   parameter int unsigned H_BACK   = H_BACK_800,
   parameter int unsigned H_DISP   = H_DISP_800,
   parameter int unsigned H_FRONT  = H_FRONT_800,
   parameter int unsigned V_SYNC   = V_SYNC_800,
   parameter int unsigned V_BACK   = V_BACK_800,
   parameter int unsigned V_DISP   = V_DISP_800,
   parameter int unsigned V_FRONT  = V_FRONT_800,
   parameter bit          SYNC_POL = 1'b1,
   parameter int unsigned LEAD     = 2
) (
   input  logic               pixel_clk,
   input  logic               sys_rst,
   input  logic [RGB_W-1:0]   pixel_data,
   output logic [COORD_W-1:0] pixel_xpos,
   output logic [COORD_W-1:0] pixel_ypos,
   output logic               data_req,
   output logic               video_hs,
   output logic               video_vs,
   output logic               video_de,
   output logic [RGB_W-1:0]   video_rgb,
   output logic               frame_start
);

   localparam int unsigned H_ACT0 = H_SYNC + H_BACK;
   // Request window is the active window shifted LEAD columns earlier
   localparam coord_t REQ_X0 = coord_t'(H_ACT0 - LEAD);
   localparam coord_t REQ_X1 = coord_t'(H_ACT0 + H_DISP - LEAD);
   localparam coord_t ACT_Y0 = coord_t'(V_SYNC + V_BACK);

   if (LEAD < 1 || LEAD > 8) begin : g_lead_range
      $error("video_timing_gen: LEAD must be in 1..8");
   end
   if (LEAD >= H_ACT0) begin : g_lead_porch
      $error("video_timing_gen: LEAD must be smaller than H_SYNC+H_BACK");
   end

   coord_t h_cnt, v_cnt;
   logic   h_wrap, h_sync, h_act;
   logic   v_wrap_unused, v_sync, v_act;

   vtg_axis_counter #(
      .Sync  (H_SYNC),
      .Back  (H_BACK),
      .Disp  (H_DISP),
      .Front (H_FRONT)
   ) u_h_axis (
      .clk_i    (pixel_clk),
      .rst_i    (sys_rst),
      .en_i     (1'b1),
      .cnt_o    (h_cnt),
      .wrap_o   (h_wrap),
      .sync_o   (h_sync),
      .active_o (h_act)
   );

   vtg_axis_counter #(
      .Sync  (V_SYNC),
      .Back  (V_BACK),
      .Disp  (V_DISP),
      .Front (V_FRONT)
   ) u_v_axis (
      .clk_i    (pixel_clk),
      .rst_i    (sys_rst),
      .en_i     (h_wrap),
      .cnt_o    (v_cnt),
      .wrap_o   (v_wrap_unused),
      .sync_o   (v_sync),
      .active_o (v_act)
   );

   logic   req_d, de_d, hs_d, vs_d, fs_d;
   coord_t xpos_d, ypos_d;
   rgb_t   rgb_d;

   logic   req_q, de_q, hs_q, vs_q, fs_q;
   coord_t xpos_q, ypos_q;
   rgb_t   rgb_q;

   // Decode the current counter state into next output values
   always_comb begin
      req_d  = v_act && (h_cnt >= REQ_X0) && (h_cnt < REQ_X1);
      de_d   = h_act && v_act;
      hs_d   = h_sync ? SYNC_POL : ~SYNC_POL;
      vs_d   = v_sync ? SYNC_POL : ~SYNC_POL;
      fs_d   = (h_cnt == '0) && (v_cnt == '0);
      // Subtraction only inside the window, so it cannot underflow
      xpos_d = req_d ? (h_cnt - REQ_X0) : '0;
      ypos_d = req_d ? (v_cnt - ACT_Y0) : '0;
`ifdef VTG_BLANK_RGB_EN
      rgb_d  = de_d ? pixel_data : BLACK;
`else
      rgb_d  = pixel_data;
`endif
   end

   // Output registers; reset forces inactive sync and zeroed data
   always_ff @(posedge pixel_clk) begin
      if (sys_rst) begin
         req_q  <= 1'b0;
         de_q   <= 1'b0;
         hs_q   <= ~SYNC_POL;
         vs_q   <= ~SYNC_POL;
         fs_q   <= 1'b0;
         xpos_q <= '0;
         ypos_q <= '0;
         rgb_q  <= BLACK;
      end else begin
         req_q  <= req_d;
         de_q   <= de_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         fs_q   <= fs_d;
         xpos_q <= xpos_d;
         ypos_q <= ypos_d;
         rgb_q  <= rgb_d;
      end
   end

   assign data_req    = req_q;
   assign video_de    = de_q;
   assign video_hs    = hs_q;
   assign video_vs    = vs_q;
   assign frame_start = fs_q;
   assign pixel_xpos  = xpos_q;
   assign pixel_ypos  = ypos_q;
   assign video_rgb   = rgb_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed + randomised bench for video_timing_gen using a reduced
// timing (29x12) instance checked cycle by cycle, plus a LEAD=4, H_DISP=640 instance.
module tb_video_timing_gen;

   localparam int HS = 4, HB = 6, HD = 16, HF = 3;
   localparam int VS = 2, VB = 3, VD = 5, VF = 2;
   localparam int LEAD = 2;
   localparam int HT = HS + HB + HD + HF;
   localparam int VT = VS + VB + VD + VF;
   localparam int FRAME = HT * VT;
   localparam int HA0 = HS + HB;
   localparam int VA0 = VS + VB;
   localparam int L4_LEAD = 4;
   localparam int L4_DISP = 640;
`ifdef VTG_BLANK_RGB_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   logic        pixel_clk = 1'b0;
   logic        sys_rst;
   logic [23:0] pixel_data;
   logic [10:0] pixel_xpos, pixel_ypos;
   logic        data_req, video_hs, video_vs, video_de, frame_start;
   logic [23:0] video_rgb;

   logic [10:0] xpos4, ypos4_unused;
   logic        req4, de4, hs4_unused, vs4_unused, fs4_unused;
   logic [23:0] rgb4_unused;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int pos = 0;

   logic [10:0] xd0 = '0, xd1 = '0;
   bit prev_de, prev_req, fs_valid;
   int fs_cyc, lines, de_run, req_rise;
   bit prev_req4, prev_de4;
   int req4_rise, n_lead4 = 0;
   logic [10:0] last_x4;

   always #5 pixel_clk = ~pixel_clk;

   video_timing_gen #(
      .H_SYNC (HS), .H_BACK (HB), .H_DISP (HD), .H_FRONT (HF),
      .V_SYNC (VS), .V_BACK (VB), .V_DISP (VD), .V_FRONT (VF),
      .SYNC_POL (1'b1), .LEAD (LEAD)
   ) dut (
      .pixel_clk (pixel_clk), .sys_rst (sys_rst), .pixel_data (pixel_data),
      .pixel_xpos (pixel_xpos), .pixel_ypos (pixel_ypos), .data_req (data_req),
      .video_hs (video_hs), .video_vs (video_vs), .video_de (video_de),
      .video_rgb (video_rgb), .frame_start (frame_start)
   );

   video_timing_gen #(
      .H_SYNC (120), .H_BACK (64), .H_DISP (L4_DISP), .H_FRONT (56),
      .V_SYNC (1), .V_BACK (1), .V_DISP (2), .V_FRONT (1),
      .SYNC_POL (1'b1), .LEAD (L4_LEAD)
   ) dut4 (
      .pixel_clk (pixel_clk), .sys_rst (sys_rst), .pixel_data (24'h000000),
      .pixel_xpos (xpos4), .pixel_ypos (ypos4_unused), .data_req (req4),
      .video_hs (hs4_unused), .video_vs (vs4_unused), .video_de (de4),
      .video_rgb (rgb4_unused), .frame_start (fs4_unused)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge pixel_clk);
      #1;
      cyc++;
   endtask

   task automatic clear_trackers();
      prev_de = 0; prev_req = 0; fs_valid = 0; lines = 0; de_run = 0; req_rise = 0;
      prev_req4 = 0; prev_de4 = 0; req4_rise = 0; last_x4 = '0;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_hs", 32'(video_hs), 0);
      chk("rst_vs", 32'(video_vs), 0);
      chk("rst_de", 32'(video_de), 0);
      chk("rst_req", 32'(data_req), 0);
      chk("rst_fs", 32'(frame_start), 0);
      chk("rst_xpos", 32'(pixel_xpos), 0);
      chk("rst_ypos", 32'(pixel_ypos), 0);
      chk("rst_rgb", 32'(video_rgb), 0);
   endtask

   // Expected outputs for frame position p (raster order, position 0 = frame start)
   task automatic check_model(input int p, input logic [23:0] pd, input int mode);
      int h, v;
      bit hact, vact, de, req;
      h = p % HT;
      v = p / HT;
      hact = (h >= HA0) && (h < HA0 + HD);
      vact = (v >= VA0) && (v < VA0 + VD);
      de = hact && vact;
      req = vact && (h >= HA0 - LEAD) && (h < HA0 + HD - LEAD);
      chk("hs", 32'(video_hs), (h < HS) ? 1 : 0);
      chk("vs", 32'(video_vs), (v < VS) ? 1 : 0);
      chk("de", 32'(video_de), de ? 1 : 0);
      chk("req", 32'(data_req), req ? 1 : 0);
      chk("fs", 32'(frame_start), (p == 0) ? 1 : 0);
      chk("xpos", 32'(pixel_xpos), req ? h - (HA0 - LEAD) : 0);
      chk("ypos", 32'(pixel_ypos), req ? v - VA0 : 0);
      chk("rgb", 32'(video_rgb), (BLANK && !de) ? 0 : 32'(pd));
      if (mode == 1 && de) chk("rgb_col", 32'(video_rgb), h - HA0);
   endtask

   // Run-length and spacing checks on the observed waveforms
   task automatic track();
      if (frame_start === 1'b1) begin
         if (fs_valid) begin
            chk("frame_period", cyc - fs_cyc, FRAME);
            chk("de_lines", lines, VD);
         end
         fs_valid = 1; fs_cyc = cyc; lines = 0;
      end
      if (data_req && !prev_req) req_rise = cyc;
      if (video_de && !prev_de) chk("lead", cyc - req_rise, LEAD);
      if (video_de) de_run++;
      if (!video_de && prev_de) begin
         chk("de_run", de_run, HD);
         lines++;
      end
      if (!video_de) de_run = 0;
      prev_de = video_de;
      prev_req = data_req;
      if (req4 && !prev_req4) begin
         req4_rise = cyc;
         chk("xpos4_first", 32'(xpos4), 0);
      end
      if (de4 && !prev_de4) begin
         chk("lead4", cyc - req4_rise, L4_LEAD);
         n_lead4++;
      end
      if (!req4 && prev_req4) chk("xpos4_last", 32'(last_x4), L4_DISP - 1);
      if (req4) last_x4 = xpos4;
      prev_req4 = req4;
      prev_de4 = de4;
   endtask

   // mode 0: random data, 1: colour stage returning xpos one cycle later, 2: constant red
   task automatic run(input int mode, input int n);
      logic [23:0] pd;
      for (int i = 0; i < n; i++) begin
         if (mode == 0) pd = 24'($urandom);
         else if (mode == 1) pd = {13'b0, xd1};
         else pd = 24'hFF0000;
         pixel_data = pd;
         tick();
         check_model(pos, pd, mode);
         track();
         xd1 = xd0;
         xd0 = pixel_xpos;
         pos = (pos + 1) % FRAME;
      end
   endtask

   initial begin
      int target;
      sys_rst = 1'b1;
      pixel_data = '0;
      clear_trackers();
      for (int i = 0; i < 5; i++) begin
         pixel_data = 24'($urandom);
         tick();
         chk_reset_outputs();
      end
      sys_rst = 1'b0;
      pos = 0;
      run(0, 4 * FRAME);
      run(1, 2 * FRAME);
      run(2, 2 * FRAME);

      // Reset pulse in the middle of an active line
      target = 6 * HT + 15;
      for (int i = 0; i < FRAME && pos != target; i++) run(0, 1);
      sys_rst = 1'b1;
      pixel_data = 24'($urandom);
      tick();
      chk_reset_outputs();
      sys_rst = 1'b0;
      clear_trackers();
      pos = 0;
      run(0, 2 * FRAME + 5);

      chk("lead4_seen", (n_lead4 > 0) ? 1 : 0, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
